// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, slave FSM state encoding and word-index helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_slv_state_t;

    // Word index of a byte address relative to a base; subtraction wraps at 32 bits.
    function automatic logic [APB_ADDR_W-3:0] apb_word_idx(
        input logic [APB_ADDR_W-1:0] addr,
        input logic [APB_ADDR_W-1:0] base
    );
        logic [APB_ADDR_W-1:0] off;
        off = addr - base;
        return off[APB_ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x 32-bit storage: one synchronous write port, one combinational read port, sync clear.
// Latency: write visible on the read port the cycle after we_i; read is combinational.
// Backpressure: none; the caller sequences all accesses.
// Ports: clk_i, clr_i (sync clear, wins over write), we_i/waddr_i/wdata_i, raddr_i -> rdata_o.
import apb_pkg::*;

module apb_regfile_mem #(
    parameter int DEPTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [APB_DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [APB_DATA_W-1:0] rdata_o
);

    logic [APB_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave register file with programmable wait states and PSLVERR on bad addresses.
// Latency: access phase lasts WAIT_CYCLES+1 cycles; PRDATA/PREADY/PSLVERR are registered.
// Backpressure: PREADY held low for WAIT_CYCLES access cycles; PSEL drop aborts with no write.
// Ports: PCLK, PRESET (sync, active-high), APB request PSEL/PENABLE/PWRITE/PADDR/PWDATA,
//        APB response PRDATA/PREADY/PSLVERR.
import apb_pkg::*;

module apb_slave_regfile #(
    parameter int                    DEPTH       = 128,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int                  IDX_W   = $clog2(DEPTH);
    localparam logic [3:0]          WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic [APB_ADDR_W-3:0] DEPTH_W = (APB_ADDR_W-2)'(DEPTH);

    apb_slv_state_t        state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [APB_DATA_W-1:0] wdat_q, wdat_d;
    logic [APB_DATA_W-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic [APB_ADDR_W-3:0] word_idx;
    logic                  dec_err;
    logic                  mem_we;
    logic [APB_DATA_W-1:0] mem_rdata;

    // Address decode on the live bus; only consumed during the setup phase.
    always_comb begin
        word_idx = apb_word_idx(PADDR, BASE_ADDR);
        dec_err  = (PADDR[1:0] != 2'b00) || (PADDR < BASE_ADDR) || (word_idx >= DEPTH_W);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                // PENABLE without a preceding setup is not a transfer start.
                if (PSEL && !PENABLE) begin
                    wr_d   = PWRITE;
                    err_d  = dec_err;
                    idx_d  = word_idx[IDX_W-1:0];
                    wdat_d = PWDATA;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = WAIT_LD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    // The edge that sees cnt==1 closes the last PREADY-low cycle.
                    if (cnt_q <= 4'd1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RESP: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    mem_we  = wr_q && !err_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response outputs are computed from next-state values so they are valid in the
    // same cycle PREADY rises. The read port is addressed with idx_d so a zero-wait
    // read sees the index being latched on this edge.
    always_comb begin
        pready_d  = (state_d == RESP);
        pslverr_d = (state_d == RESP) && err_d;
        prdata_d  = prdata_q;
        if ((state_d == RESP) && (state_q != RESP) && !wr_d) begin
            prdata_d = err_d ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdat_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            wdat_q    <= wdat_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Reset clears storage and masks any commit that would land on the same edge.
    apb_regfile_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i   (PCLK),
        .clr_i   (PRESET),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdat_q),
        .raddr_i (idx_d),
        .rdata_o (mem_rdata)
    );

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule
